// File: rtl/mul_accumulator.sv
// mul_accumulator: sums LEN unsigned 8-bit products into one ACC_W-bit block
// result. Products arrive over a valid/ready handshake. The result leaves over
// a second valid/ready handshake.
// Optional build macro MUL_ACC_SAT_EN: when defined, adds saturate at
// 2^ACC_W-1. When undefined (the default), adds wrap modulo 2^ACC_W.
// In both builds ovf flags the overflow.
module mul_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       p_in,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;

    logic               xfer;
    logic               last_beat;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   add_res;

    // Inputs are refused while the result waits, during clear and during rst.
    assign p_ready   = (state_reg != OUT) && !clear && !rst;
    assign xfer      = p_valid && p_ready;
    assign p_ext     = ACC_W'(p_in);
    assign sum       = {1'b0, acc_reg} + {1'b0, p_ext};
    assign carry     = sum[ACC_W];
    assign last_beat = (cnt_reg == CNT_W'(LEN - 1));

`ifdef MUL_ACC_SAT_EN
    // Clamp at all-ones. Once at max, later adds keep it there.
    assign add_res = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    // Wrap modulo 2^ACC_W by dropping the carry.
    assign add_res = sum[ACC_W-1:0];
`endif

    assign acc_out   = acc_reg;
    assign acc_valid = (state_reg == OUT);
    assign busy      = (state_reg == ACCUM);
    assign ovf       = ovf_reg;

    // Next-state and datapath update. clear wins over any handshake.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        acc_next   = p_ext;
                        cnt_next   = CNT_W'(1);
                        ovf_next   = 1'b0;
                        state_next = (LEN == 1) ? OUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_next = add_res;
                        cnt_next = cnt_reg + CNT_W'(1);
                        ovf_next = ovf_reg | carry;
                        if (last_beat) begin
                            state_next = OUT;
                        end
                    end
                end
                OUT: begin
                    if (acc_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator. Two instances share one stimulus bus:
// inst0 uses the defaults (ACC_W=16, LEN=8), and inst1 uses ACC_W=8, LEN=2.
// A block-level model checks both instances on every cycle. Directed checks
// with hand-computed values pin the model. Honours MUL_ACC_SAT_EN.
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        p_valid = 1'b0;
    logic [7:0]  p_in = 8'd0;
    logic        acc_ready = 1'b1;

    logic        p_ready0, acc_valid0, busy0, ovf0;
    logic [15:0] acc_out0;
    logic        p_ready1, acc_valid1, busy1, ovf1;
    logic [7:0]  acc_out1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mul_accumulator #(.ACC_W(16), .LEN(8), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready0),
        .clear(clear), .acc_out(acc_out0), .acc_valid(acc_valid0),
        .acc_ready(acc_ready), .busy(busy0), .ovf(ovf0)
    );

    mul_accumulator #(.ACC_W(8), .LEN(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready1),
        .clear(clear), .acc_out(acc_out1), .acc_valid(acc_valid1),
        .acc_ready(acc_ready), .busy(busy1), .ovf(ovf1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: each block is the true integer sum of its accepted products.
    int     w_of [2] = '{16, 8};
    int     l_of [2] = '{8, 2};
    longint m_sum [2];
    int     m_cnt [2];
    bit     m_out [2];
    bit     started = 1'b0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
            m_out[i] = 1'b0;
        end
    end

    function automatic longint exp_acc(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef MUL_ACC_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    function automatic bit exp_ovf(input longint s, input int w);
        return s > ((longint'(1) << w) - 1);
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst || clear) begin
                m_sum[i] <= 0;
                m_cnt[i] <= 0;
                m_out[i] <= 1'b0;
            end else if (m_out[i]) begin
                if (acc_ready) begin
                    m_out[i] <= 1'b0;
                    $display("[TB] inst%0d block delivered sum=%0d", i, m_sum[i]);
                end
            end else if (p_valid) begin
                m_sum[i] <= (m_cnt[i] == 0) ? longint'(p_in) : m_sum[i] + longint'(p_in);
                if (m_cnt[i] + 1 == l_of[i]) begin
                    m_cnt[i] <= 0;
                    m_out[i] <= 1'b1;
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("inst%0d acc_out", i),
                      (i == 0) ? longint'(acc_out0) : longint'(acc_out1),
                      exp_acc(m_sum[i], w_of[i]));
                check($sformatf("inst%0d acc_valid", i),
                      (i == 0) ? longint'(acc_valid0) : longint'(acc_valid1),
                      longint'(m_out[i]));
                check($sformatf("inst%0d busy", i),
                      (i == 0) ? longint'(busy0) : longint'(busy1),
                      longint'(m_cnt[i] != 0 && !m_out[i]));
                check($sformatf("inst%0d ovf", i),
                      (i == 0) ? longint'(ovf0) : longint'(ovf1),
                      longint'(exp_ovf(m_sum[i], w_of[i])));
                check($sformatf("inst%0d p_ready", i),
                      (i == 0) ? longint'(p_ready0) : longint'(p_ready1),
                      longint'(!m_out[i] && !clear && !rst));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        p_valid = 1'b1;
        p_in    = v;
        tick();
    endtask

    initial begin
        // Reset held for two cycles.
        tick();
        check("rst p_ready", p_ready0, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post-rst p_ready", p_ready0, 1);
        check("post-rst acc_out", acc_out0, 0);
        check("post-rst acc_valid", acc_valid0, 0);
        check("post-rst busy", busy0, 0);
        check("post-rst ovf", ovf0, 0);
        tick();

        // 8 back-to-back products of 225.
        acc_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(8'd225);
        p_valid = 1'b0;
        check("t2 acc_valid", acc_valid0, 1);
        check("t2 acc_out", acc_out0, 1800);
        check("t2 ovf", ovf0, 0);
        tick();
        check("t2 valid drop", acc_valid0, 0);
        check("t2 acc held", acc_out0, 1800);

        // Backpressure: result held while acc_ready is low.
        acc_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(8'd10);
        p_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            p_valid = (k % 2 == 0);
            p_in    = 8'd99;
            tick();
            check("t3 held acc", acc_out0, 80);
            check("t3 held valid", acc_valid0, 1);
            check("t3 p_ready low", p_ready0, 0);
        end
        p_valid   = 1'b0;
        acc_ready = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) send(8'(k));
        p_valid = 1'b0;
        check("t3 sum 1..8", acc_out0, 36);
        check("t3 valid", acc_valid0, 1);
        tick();

        // Bubbles: valid on every other cycle.
        for (int k = 0; k < 15; k++) begin
            p_valid = (k % 2 == 0);
            p_in    = 8'd15;
            tick();
            if (k < 14) check("t4 busy", busy0, 1);
        end
        p_valid = 1'b0;
        check("t4 acc_out", acc_out0, 120);
        check("t4 valid", acc_valid0, 1);
        check("t4 busy end", busy0, 0);
        tick();

        // clear mid-block with a coincident valid beat.
        for (int k = 0; k < 3; k++) send(8'd50);
        check("t5 partial", acc_out0, 150);
        clear   = 1'b1;
        p_valid = 1'b1;
        p_in    = 8'd50;
        #1;
        check("t5 p_ready on clear", p_ready0, 0);
        tick();
        clear   = 1'b0;
        p_valid = 1'b0;
        check("t5 cleared acc", acc_out0, 0);
        check("t5 cleared busy", busy0, 0);
        for (int k = 0; k < 8; k++) send(8'd1);
        p_valid = 1'b0;
        check("t5 sum of ones", acc_out0, 8);
        tick();

        // Overflow on the ACC_W=8, LEN=2 instance.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(8'd200);
        send(8'd100);
        p_valid = 1'b0;
`ifdef MUL_ACC_SAT_EN
        check("t6 sat acc", acc_out1, 255);
`else
        check("t6 wrap acc", acc_out1, 44);
`endif
        check("t6 ovf", ovf1, 1);
        check("t6 valid", acc_valid1, 1);
        tick();
        check("t6 ovf sticky", ovf1, 1);
        send(8'd1);
        send(8'd2);
        p_valid = 1'b0;
        check("t6 next acc", acc_out1, 3);
        check("t6 next ovf", ovf1, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
